fm0_decoder: RTL and testbench

- Sits directly downstream of the receive-path sampler. Consumes its synchronised, strobed sample stream (one sample per valid strobe) and decodes FM0 tag backscatter into a bit stream.
- Measures run lengths between level transitions, counted in valid samples. Each run is classified as a half-symbol or a full-symbol.
  - One full run emits data-1.
  - Two consecutive half runs emit data-0.
- Flags malformed timing and signals end-of-frame when the line stops toggling.

---
 rtl/fm0_decoder.sv | 132 +++++++++++++
 tb/tb_fm0_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm0_decoder.sv
// FM0 backscatter decoder: measures run lengths between line transitions on a strobed
// sample stream and turns one full run into a 1 and two half runs into a 0.
module fm0_decoder #(
   parameter int HALF_MIN = 3,
   parameter int HALF_MAX = 6,
   parameter int FULL_MIN = 7,
   parameter int FULL_MAX = 12,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       in_dat,
   input  logic       in_vld,
   output logic       out_bit,
   output logic       out_vld,
   output logic       err,
   output logic       done,
   output logic       busy,
   output logic [1:0] dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             prev_q;
   logic             pending_q;
   logic             out_bit_q;
   logic             out_vld_q;
   logic             err_q;
   logic             done_q;
   logic             busy_q;

   logic [CNT_W-1:0] cnt_inc;
   logic             is_half;
   logic             is_full;
   logic             timeout;

   // cnt_q is the length of the run that the current transition sample closes.
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign is_half = (cnt_q >= CNT_W'(HALF_MIN)) && (cnt_q <= CNT_W'(HALF_MAX));
   assign is_full = (cnt_q >= CNT_W'(FULL_MIN)) && (cnt_q <= CNT_W'(FULL_MAX));
   assign timeout = cnt_inc > CNT_W'(FULL_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         prev_q    <= 1'b0;
         pending_q <= 1'b0;
         out_bit_q <= 1'b0;
         out_vld_q <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         out_vld_q <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         if (!en) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
         end else if (in_vld) begin
            case (state_q)
               IDLE: begin
                  state_q   <= SYNC;
                  busy_q    <= 1'b1;
                  prev_q    <= in_dat;
                  pending_q <= 1'b0;
                  cnt_q     <= '0;
               end
               SYNC: begin
                  if (in_dat != prev_q) begin
                     prev_q  <= in_dat;
                     cnt_q   <= CNT_W'(1);
                     state_q <= RUN;
                  end
               end
               RUN: begin
                  if (in_dat == prev_q) begin
                     cnt_q <= cnt_inc;
                     if (timeout) begin
                        // A line that stops toggling ends the frame; mid-symbol it is a fault.
                        err_q     <= pending_q;
                        done_q    <= !pending_q;
                        pending_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= SYNC;
                     end
                  end else begin
                     prev_q <= in_dat;
                     cnt_q  <= CNT_W'(1);
                     if (is_half) begin
                        if (pending_q) begin
                           out_bit_q <= 1'b0;
                           out_vld_q <= 1'b1;
                        end
                        pending_q <= !pending_q;
                     end else if (is_full && !pending_q) begin
                        out_bit_q <= 1'b1;
                        out_vld_q <= 1'b1;
                     end else begin
                        err_q     <= 1'b1;
                        pending_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= SYNC;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign out_bit     = out_bit_q;
   assign out_vld     = out_vld_q;
   assign err         = err_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fm0_decoder.sv
// Bench for fm0_decoder: frames are described as run-length lists, a run-level model
// predicts each pulse and the strobe index that causes it, and a monitor checks them.
module tb_fm0_decoder;

   localparam int HALF_MIN = 3;
   localparam int HALF_MAX = 6;
   localparam int FULL_MIN = 7;
   localparam int FULL_MAX = 12;
   localparam int K_BIT  = 1;
   localparam int K_ERR  = 2;
   localparam int K_DONE = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       in_dat;
   logic       in_vld;
   logic       out_bit;
   logic       out_vld;
   logic       err;
   logic       done;
   logic       busy;
   logic [1:0] dbg_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   int cur_idx  = -1;
   int last_idx = -1;
   int gidx     = 0;
   int gap_min  = 1;
   int gap_max  = 3;
   int runs_q[$];
   logic lv[$];

   // clock / reset
   always #5 clk = ~clk;

   fm0_decoder dut (
      .clk(clk), .rst(rst), .en(en), .in_dat(in_dat), .in_vld(in_vld),
      .out_bit(out_bit), .out_vld(out_vld), .err(err), .done(done), .busy(busy),
      .dbg_state_o(dbg_state)
   );

   function automatic logic [31:0] mk(input int kind, input logic b, input int idx);
      logic [19:0] i20;
      i20 = idx[19:0];
      return {kind[1:0], b, 9'd0, i20};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(posedge clk) last_idx <= in_vld ? cur_idx : -1;

   logic [31:0] mon_e, mon_a;
   int mon_k;
   always @(negedge clk) begin
      if (out_vld || err || done) begin
         total++;
         mon_k = out_vld ? K_BIT : (err ? K_ERR : K_DONE);
         mon_a = mk(mon_k, out_vld ? out_bit : 1'b0, last_idx);
         if ($countones({out_vld, err, done}) > 1) begin
            bad++;
            $display("FAIL pulse_excl: vld=%0b err=%0b done=%0b", out_vld, err, done);
         end else if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got kind=%0d bit=%0b after strobe %0d, expected none",
                     mon_k, out_bit, last_idx);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a != mon_e) begin
               bad++;
               $display("FAIL pulse: got kind=%0d bit=%0b strobe=%0d expected kind=%0d bit=%0b strobe=%0d",
                        mon_a[31:30], mon_a[29], mon_a[19:0], mon_e[31:30], mon_e[29], mon_e[19:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic strobe(input logic d);
      int g;
      g = $urandom_range(gap_min, gap_max);
      for (int i = 1; i < g; i++) begin
         @(negedge clk);
         in_vld = 1'b0;
         in_dat = 1'($urandom);
      end
      @(negedge clk);
      in_vld  = 1'b1;
      in_dat  = d;
      cur_idx = gidx;
      gidx++;
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_vld = 1'b0;
      end
   endtask

   function automatic int next_edge(input int from);
      for (int i = from; i < lv.size(); i++)
         if (lv[i] != lv[i-1]) return i;
      return lv.size();
   endfunction

   // Run-level reference: walk transitions of the whole frame and apply the symbol rules.
   task automatic model_frame(input int base);
      int n, pos, nxt, len;
      bit pend;
      n = lv.size();
      pend = 0;
      pos = next_edge(1);
      while (pos < n) begin
         nxt = next_edge(pos + 1);
         len = nxt - pos;
         if (len > FULL_MAX) begin
            exp_q.push_back(mk(pend ? K_ERR : K_DONE, 1'b0, base + pos + FULL_MAX));
            pend = 0;
            pos = nxt;
         end else if (nxt == n) begin
            break;
         end else if (len >= HALF_MIN && len <= HALF_MAX) begin
            if (pend) exp_q.push_back(mk(K_BIT, 1'b0, base + nxt));
            pend = !pend;
            pos = nxt;
         end else if (len >= FULL_MIN && len <= FULL_MAX && !pend) begin
            exp_q.push_back(mk(K_BIT, 1'b1, base + nxt));
            pos = nxt;
         end else begin
            exp_q.push_back(mk(K_ERR, 1'b0, base + nxt));
            pend = 0;
            pos = next_edge(nxt + 1);
         end
      end
   endtask

   task automatic run_frame(input logic start_lvl);
      logic l;
      lv.delete();
      l = start_lvl;
      foreach (runs_q[r]) begin
         for (int k = 0; k < runs_q[r]; k++) lv.push_back(l);
         l = ~l;
      end
      model_frame(gidx);
      @(negedge clk);
      en      = 1'b1;
      in_vld  = 1'b1;
      in_dat  = lv[0];
      cur_idx = gidx;
      gidx++;
      for (int i = 1; i < lv.size(); i++) strobe(lv[i]);
      quiet(3);
   endtask

   task automatic drop_en();
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("busy_after_en_drop", int'(busy), 0);
   endtask

   function automatic int rand_len();
      int c;
      c = $urandom_range(0, 19);
      if (c < 2) return $urandom_range(1, 2);
      if (c < 3) return $urandom_range(13, 15);
      if (c < 11) return $urandom_range(HALF_MIN, HALF_MAX);
      return $urandom_range(FULL_MIN, FULL_MAX);
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; in_dat = 1'b0; in_vld = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_out_vld", int'(out_vld), 0);
      check("reset_err", int'(err), 0);
      check("reset_done", int'(done), 0);
      check("reset_state", int'(dbg_state), 0);

      gap_min = 10; gap_max = 10;
      runs_q = '{2, 10, 5, 5, 10, 1};
      run_frame(1'b0);
      check("decode_busy", int'(busy), 1);
      drop_en();

      gap_min = 1; gap_max = 3;
      runs_q = '{2, 2, 3, 8, 1};
      run_frame(1'b1);
      check("glitch_busy", int'(busy), 1);
      drop_en();

      runs_q = '{2, 4, 9, 1};
      run_frame(1'b0);
      check("proto_busy", int'(busy), 1);
      check("proto_state_sync", int'(dbg_state), 1);
      drop_en();

      runs_q = '{2, 8, 13};
      run_frame(1'b0);
      drop_en();
      runs_q = '{2, 4, 13};
      run_frame(1'b1);
      drop_en();

      runs_q = '{2, 5, 1};
      run_frame(1'b0);
      drop_en();
      runs_q = '{3, 8, 1};
      run_frame(1'b1);
      drop_en();

      // async reset while a half symbol is pending
      runs_q = '{2, 5, 2};
      run_frame(1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_out_vld", int'(out_vld), 0);
      check("async_rst_err", int'(err), 0);
      check("async_rst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      strobe(1'b1);
      quiet(1);
      check("restart_busy", int'(busy), 1);
      check("restart_state_sync", int'(dbg_state), 1);
      drop_en();

      for (int f = 0; f < 40; f++) begin
         gap_min = 1;
         gap_max = $urandom_range(1, 4);
         runs_q.delete();
         runs_q.push_back($urandom_range(1, 3));
         for (int r = 0; r < $urandom_range(3, 10); r++) runs_q.push_back(rand_len());
         run_frame(1'($urandom));
         drop_en();
      end

      quiet(4);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
